// File: rtl/pw_det_pkg.sv
// Shared types for the pulse-width detector.
package pw_det_pkg;

  // ARM waits for a clean low input, IDLE waits for a rising edge,
  // MEASURE accumulates reference ticks while the input is high.
  typedef enum logic [1:0] {
    ARM     = 2'd0,
    IDLE    = 2'd1,
    MEASURE = 2'd2
  } pw_state_t;

endpackage

// File: rtl/ref_tick_gen.sv
// Free-running reference tick generator: one-cycle tick every DIV clkin cycles.
module ref_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clkin,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Count 0..DIV-1 and wrap; only reset clears it, enable has no effect.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/pw_detector.sv
// Pulse-width detector: synchronises sig_in, counts reference ticks while it
// is high and reports the width (or a glitch) one strobe per falling edge.
module pw_detector
  import pw_det_pkg::*;
#(
  parameter int DIV         = 4,
  parameter int CNT_W       = 8,
  parameter int MIN_W       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] pw_value,
  output logic             pw_valid,
  output logic             pw_ovf,
  output logic             glitch,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_VAL = CNT_W'(MIN_W);

  logic                   tick;
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   s_prev;
  logic                   hi;
  logic                   rise;
  logic                   fall;
  logic                   sync_ready;

  pw_state_t        state;
  pw_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             sat;
  logic             sat_next;
  logic [CNT_W-1:0] value_next;
  logic             ovf_next;
  logic             valid_next;
  logic             glitch_next;

  ref_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clkin (clkin),
    .reset (reset),
    .tick  (tick)
  );

  // Synchronise the asynchronous input and keep the previous last-stage value.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      sync   <= '0;
      s_prev <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig_in};
      s_prev <= sync[SYNC_STAGES-1];
    end
  end

  // The synchroniser holds reset zeros for SYNC_STAGES cycles after reset
  // release; this marks when its output reflects sig_in, so that an input
  // already high at release is not mistaken for a fresh low and then a rise.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      fill <= '0;
    end else begin
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign hi         = sync[SYNC_STAGES-1];
  assign rise       = hi & ~s_prev;
  assign fall       = ~hi & s_prev;
  assign sync_ready = fill[SYNC_STAGES-1];

  // State, counter and registered outputs.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state    <= ARM;
      cnt      <= '0;
      sat      <= 1'b0;
      pw_value <= '0;
      pw_ovf   <= 1'b0;
      pw_valid <= 1'b0;
      glitch   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      sat      <= sat_next;
      pw_value <= value_next;
      pw_ovf   <= ovf_next;
      pw_valid <= valid_next;
      glitch   <= glitch_next;
    end
  end

  // Next-state, tick accumulation and pulse decision at the falling edge.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    sat_next    = sat;
    value_next  = pw_value;
    ovf_next    = pw_ovf;
    valid_next  = 1'b0;
    glitch_next = 1'b0;

    if (!en) begin
      state_next = ARM;
      sat_next   = 1'b0;
    end else begin
      case (state)
        ARM: begin
          if (!hi && sync_ready) begin
            state_next = IDLE;
          end
        end
        IDLE: begin
          if (rise) begin
            state_next = MEASURE;
            cnt_next   = tick ? CNT_W'(1) : '0;
            sat_next   = 1'b0;
          end
        end
        MEASURE: begin
          if (fall) begin
            state_next = IDLE;
            sat_next   = 1'b0;
            if (cnt >= MIN_VAL) begin
              value_next = cnt;
              ovf_next   = sat;
              valid_next = 1'b1;
            end else begin
              glitch_next = 1'b1;
            end
          end else if (hi && tick) begin
            if (cnt != CNT_MAX) begin
              cnt_next = cnt + CNT_W'(1);
            end
            if (cnt >= CNT_MAX - CNT_W'(1)) begin
              sat_next = 1'b1;
            end
          end
        end
        default: begin
          state_next = ARM;
        end
      endcase
    end
  end

  assign busy = (state == MEASURE);

endmodule
